hazard_stall_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core. Generates the write-enable, flush and bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Detects load-use hazards and flushes on branches taken in ID.
- Stalls the entire pipe while a multi-cycle data-memory access is outstanding, with a timeout fault and a saturating stall-cycle counter.

---
 rtl/hazard_stall_ctrl_if.sv | 49 ++++
 rtl/hazard_stall_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if
//   Groups the hazard/stall controller's pipeline-facing signals.
//   master : the pipeline side. It drives the hazard and memory status and
//            receives the register enables, flushes and status outputs.
//   slave  : the controller side, used by hazard_stall_ctrl.
//   Signals:
//     idex_memread_i, idex_rt_i   load in EX and its destination register
//     ifid_rs_i, ifid_rt_i        source registers of the instruction in ID
//     branch_taken_i              branch resolved taken in ID
//     exmem_memread_i/_memwrite_i memory access in MEM
//     dmem_ack_i                  data memory completes the access this cycle
//     *_write_o, *_flush_o, memwb_bubble_o, dmem_req_o   pipeline controls
//     mem_timeout_o, stall_cnt_o  fault flag and stall-cycle counter
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             branch_taken_i;
    logic             exmem_memread_i;
    logic             exmem_memwrite_i;
    logic             dmem_ack_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_write_o;
    logic             idex_flush_o;
    logic             exmem_write_o;
    logic             memwb_bubble_o;
    logic             dmem_req_o;
    logic             mem_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, branch_taken_i,
               exmem_memread_i, exmem_memwrite_i, dmem_ack_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o,
               exmem_write_o, memwb_bubble_o, dmem_req_o, mem_timeout_o, stall_cnt_o
    );

    modport slave (
        input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, branch_taken_i,
               exmem_memread_i, exmem_memwrite_i, dmem_ack_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o,
               exmem_write_o, memwb_bubble_o, dmem_req_o, mem_timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Central sequencer for the 5-stage pipeline. It drives the PC and
//   pipeline-register enables, flushes and bubbles. It also handles these events:
//     - load-use hazards, by holding PC/IF-ID and inserting an ID/EX bubble;
//     - branches taken in ID, by flushing IF/ID;
//     - multi-cycle data-memory accesses, by freezing the whole pipe until ack.
//   If an access waits more than TIMEOUT cycles in MEM_WAIT, the controller
//   moves to FAULT. It leaves FAULT only on reset.
//   Ports:
//     clk_i  clock, rising edge
//     rst_i  asynchronous active-low reset. While it is low, every enable is 0
//            and the MEM/WB bubble is 1.
//     bus    hazard_stall_ctrl_if.slave (pipeline status in, controls out)
module hazard_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int WAIT_W  = 8,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hazard_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wcnt, wcnt_nxt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              mem_timeout, timeout_set;

    logic memreq, hazard;
    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic exmem_write, memwb_bubble, dmem_req;

    // Saturating increment: the counter stops at all-ones and does not wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + CNT_W'(1);
    endfunction

    assign memreq = bus.exmem_memread_i | bus.exmem_memwrite_i;

    // Register 0 is hardwired to zero, so a load that targets it never creates a hazard.
    assign hazard = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                    ((bus.idex_rt_i == bus.ifid_rs_i) || (bus.idex_rt_i == bus.ifid_rt_i));

    always_comb begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_write   = 1'b0;
        idex_flush   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
        dmem_req     = 1'b0;
        state_nxt    = state;
        wcnt_nxt     = wcnt;
        timeout_set  = 1'b0;

        if (rst_i) begin
            unique case (state)
                RUN: begin
                    if (memreq && !bus.dmem_ack_i) begin
                        // The first stalled cycle counts toward the timeout, so the count starts at 1.
                        dmem_req  = 1'b1;
                        state_nxt = MEM_WAIT;
                        wcnt_nxt  = WAIT_W'(1);
                    end else if (hazard) begin
                        // The branch in ID stays held and is evaluated again next cycle, so it is not flushed here.
                        idex_flush  = 1'b1;
                        idex_write  = 1'b1;
                        exmem_write = 1'b1;
                        memwb_bubble = 1'b0;
                        dmem_req    = memreq;
                    end else begin
                        pc_write     = 1'b1;
                        ifid_write   = 1'b1;
                        idex_write   = 1'b1;
                        exmem_write  = 1'b1;
                        memwb_bubble = 1'b0;
                        ifid_flush   = bus.branch_taken_i;
                        dmem_req     = memreq;
                    end
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    if (bus.dmem_ack_i) begin
                        // Release cycle: MEM/WB captures the completed access.
                        pc_write     = 1'b1;
                        ifid_write   = 1'b1;
                        idex_write   = 1'b1;
                        exmem_write  = 1'b1;
                        memwb_bubble = 1'b0;
                        state_nxt    = RUN;
                        wcnt_nxt     = '0;
                    end else if (wcnt == WAIT_W'(TIMEOUT)) begin
                        state_nxt   = FAULT;
                        timeout_set = 1'b1;
                    end else begin
                        wcnt_nxt = wcnt + WAIT_W'(1);
                    end
                end
                default: begin
                    // FAULT: the pipe stays frozen and an ack has no effect.
                    state_nxt = FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= RUN;
            wcnt        <= '0;
            stall_cnt   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (timeout_set)
                mem_timeout <= 1'b1;
            if ((state == RUN || state == MEM_WAIT) && !pc_write)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign bus.pc_write_o     = pc_write;
    assign bus.ifid_write_o   = ifid_write;
    assign bus.ifid_flush_o   = ifid_flush;
    assign bus.idex_write_o   = idex_write;
    assign bus.idex_flush_o   = idex_flush;
    assign bus.exmem_write_o  = exmem_write;
    assign bus.memwb_bubble_o = memwb_bubble;
    assign bus.dmem_req_o     = dmem_req;
    assign bus.mem_timeout_o  = mem_timeout;
    assign bus.stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
//   Directed bench for hazard_stall_ctrl, built with TIMEOUT=4 and CNT_W=4.
//   Each step drives the inputs just after a rising edge and queues the outputs
//   it expects. At the falling edge it pops that entry and compares it with the
//   DUT outputs.
//   Control vector bit order:
//     {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
//      exmem_write, memwb_bubble, dmem_req}
module tb_hazard_stall_ctrl;

    localparam logic [7:0] C_NORM   = 8'hD4; // normal flow
    localparam logic [7:0] C_BRANCH = 8'hF4; // normal flow with IF/ID flush
    localparam logic [7:0] C_NORM_M = 8'hD5; // normal flow or release, dmem_req high
    localparam logic [7:0] C_HAZ    = 8'h1C; // load-use stall
    localparam logic [7:0] C_HAZ_M  = 8'h1D; // load-use stall with a completing access
    localparam logic [7:0] C_MSTALL = 8'h03; // memory stall
    localparam logic [7:0] C_DEAD   = 8'h02; // reset or FAULT

    typedef struct {
        string       tag;
        logic [12:0] val; // {ctl[7:0], mem_timeout, stall_cnt[3:0]}
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    hazard_stall_ctrl_if #(.CNT_W(4)) bus ();

    hazard_stall_ctrl #(
        .TIMEOUT(4),
        .WAIT_W (8),
        .CNT_W  (4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                         input logic [4:0] rt_id, input logic br, input logic emr,
                         input logic emw, input logic ack);
        bus.idex_memread_i   = mr;
        bus.idex_rt_i        = rt;
        bus.ifid_rs_i        = rs;
        bus.ifid_rt_i        = rt_id;
        bus.branch_taken_i   = br;
        bus.exmem_memread_i  = emr;
        bus.exmem_memwrite_i = emw;
        bus.dmem_ack_i       = ack;
    endtask

    // Queues the expectation, compares it at the falling edge, and then returns
    // just after the next rising edge so the caller can drive the next cycle.
    task automatic step(input string tag, input logic [7:0] ctl, input logic tmo,
                        input logic [3:0] cnt);
        exp_t e, p;
        logic [12:0] got;
        e.tag = tag;
        e.val = {ctl, tmo, cnt};
        sb.push_back(e);
        @(negedge clk);
        p = sb.pop_front();
        got = {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.idex_write_o,
               bus.idex_flush_o, bus.exmem_write_o, bus.memwb_bubble_o, bus.dmem_req_o,
               bus.mem_timeout_o, bus.stall_cnt_o};
        checks++;
        assert (got === p.val)
        else begin
            errors++;
            $error("FAIL %s got ctl=%h tmo=%b cnt=%0d expected ctl=%h tmo=%b cnt=%0d",
                   p.tag, got[12:5], got[4], got[3:0], p.val[12:5], p.val[4], p.val[3:0]);
        end
        @(posedge clk);
        #1;
    endtask

    // Pulses reset between clock edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        step("reset_state", C_DEAD, 0, 0);
        rst_n = 1'b1;

        // Load-use hazard while a branch is taken in ID.
        drive(1, 5, 5, 0, 1, 0, 0, 0);
        step("lu_stall", C_HAZ, 0, 0);
        drive(0, 5, 5, 0, 1, 0, 0, 0);
        step("lu_then_branch", C_BRANCH, 0, 1);

        // A load into register 0 never stalls.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step("zero_exempt", C_NORM, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("zero_cnt_same", C_NORM, 0, 1);

        // Single-cycle memory access; ifid_rt match also triggers hazard below.
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        step("mem_1cyc", C_NORM_M, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step("mem_1cyc_run", C_NORM, 0, 1);
        drive(1, 7, 0, 7, 0, 1, 0, 1);
        step("lu_rt_mem", C_HAZ_M, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("lu_rt_after", C_NORM, 0, 2);

        // Multi-cycle store, ack three cycles after the request.
        pulse_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step("mw_stall1", C_MSTALL, 0, 0);
        step("mw_stall2", C_MSTALL, 0, 1);
        step("mw_stall3", C_MSTALL, 0, 2);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        step("mw_release", C_NORM_M, 0, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("mw_back_run", C_NORM, 0, 3);

        // Timeout: five stalled cycles, then FAULT.
        pulse_reset();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            step($sformatf("to_stall%0d", i), C_MSTALL, 0, 4'(i));
        step("fault_entered", C_DEAD, 1, 5);
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        step("fault_ack_ignored", C_DEAD, 1, 5);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("fault_frozen", C_DEAD, 1, 5);
        rst_n = 1'b0;
        step("fault_in_reset", C_DEAD, 0, 0);
        rst_n = 1'b1;
        step("fault_cleared", C_NORM, 0, 0);

        // Reset asserted mid-MEM_WAIT drops dmem_req immediately.
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        step("mw2_stall1", C_MSTALL, 0, 0);
        step("mw2_stall2", C_MSTALL, 0, 1);
        rst_n = 1'b0;
        step("mw2_async_rst", C_DEAD, 0, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("mw2_run", C_NORM, 0, 0);

        // Saturation over twenty load-use stalls, then an async reset.
        drive(1, 9, 3, 9, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step($sformatf("sat%0d", i), C_HAZ, 0, (i > 15) ? 4'd15 : 4'(i));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("sat_hold", C_NORM, 0, 15);
        rst_n = 1'b0;
        step("sat_async_rst", C_DEAD, 0, 0);
        rst_n = 1'b1;
        step("sat_after_rst", C_NORM, 0, 0);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
